// File: rtl/pci_cfg_arbiter.sv
// Arbiter/sequencer for the single-ported PCI configuration register file.
// Bus target has priority over the local port; partial writes become read-modify-write.
module pci_cfg_arbiter #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_en,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_offset,
   input  logic [3:0]        bus_be,
   input  logic [31:0]       bus_wdata,
   output logic              bus_busy,
   output logic              bus_done,
   output logic [31:0]       bus_rdata,
   output logic              bus_ovf,
   input  logic              loc_req,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_offset,
   input  logic [3:0]        loc_be,
   input  logic [31:0]       loc_wdata,
   output logic              loc_ack,
   output logic [31:0]       loc_rdata,
   output logic              rf_en,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [31:0]       rf_wdata,
   input  logic [31:0]       rf_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t              state;
   logic                op_loc;
   logic                op_we;
   logic [ADDR_W-1:0]   op_offset;
   logic [3:0]          op_be;
   logic [31:0]         op_data;

   logic                pend_v;
   logic                pend_we;
   logic [ADDR_W-1:0]   pend_offset;
   logic [3:0]          pend_be;
   logic [31:0]         pend_wdata;

   logic                sel_valid;
   logic                sel_loc;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_offset;
   logic [3:0]          sel_be;
   logic [31:0]         sel_wdata;

   logic                fin;
   logic                fin_loc;
   logic [31:0]         fin_data;
   logic [31:0]         cap_data;

   function automatic logic [31:0] merge_bytes(input logic [3:0] be,
                                               input logic [31:0] wdata,
                                               input logic [31:0] rdata);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
      end
      return res;
   endfunction

   function automatic state_t first_state(input logic we, input logic [3:0] be);
      if (!we) begin
         return RD;
      end else if (be == 4'hF) begin
         return WR;
      end else if (be == 4'h0) begin
         return DONE;
      end else begin
         return RD;
      end
   endfunction

   // Winning request in IDLE: pending bus entry, then live bus strobe, then local port.
   always_comb begin
      sel_valid  = 1'b0;
      sel_loc    = 1'b0;
      sel_we     = 1'b0;
      sel_offset = {ADDR_W{1'b0}};
      sel_be     = 4'h0;
      sel_wdata  = 32'h0;
      if (state != IDLE) begin
         sel_valid = 1'b0;
      end else if (pend_v) begin
         sel_valid  = 1'b1;
         sel_we     = pend_we;
         sel_offset = pend_offset;
         sel_be     = pend_be;
         sel_wdata  = pend_wdata;
      end else if (bus_en) begin
         sel_valid  = 1'b1;
         sel_we     = bus_we;
         sel_offset = bus_offset;
         sel_be     = bus_be;
         sel_wdata  = bus_wdata;
      end else if (loc_req && !loc_ack) begin
         sel_valid  = 1'b1;
         sel_loc    = 1'b1;
         sel_we     = loc_we;
         sel_offset = loc_offset;
         sel_be     = loc_be;
         sel_wdata  = loc_wdata;
      end else begin
         sel_valid = 1'b0;
      end
   end

   // Data captured in CAP and the completion that the next edge moves into DONE.
   always_comb begin
      cap_data = op_we ? merge_bytes(op_be, op_data, rf_rdata) : rf_rdata;
      fin      = 1'b0;
      fin_loc  = op_loc;
      fin_data = op_data;
      case (state)
         IDLE: begin
            fin      = sel_valid && sel_we && (sel_be == 4'h0);
            fin_loc  = sel_loc;
            fin_data = sel_wdata;
         end
         CAP: begin
            fin      = !op_we;
            fin_data = rf_rdata;
         end
         WR: begin
            fin = 1'b1;
         end
         default: begin
            fin = 1'b0;
         end
      endcase
   end

   // Sequencer, pending bus slot and completion strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         op_loc      <= 1'b0;
         op_we       <= 1'b0;
         op_offset   <= {ADDR_W{1'b0}};
         op_be       <= 4'h0;
         op_data     <= 32'h0;
         pend_v      <= 1'b0;
         pend_we     <= 1'b0;
         pend_offset <= {ADDR_W{1'b0}};
         pend_be     <= 4'h0;
         pend_wdata  <= 32'h0;
         bus_ovf     <= 1'b0;
         bus_done    <= 1'b0;
         bus_rdata   <= 32'h0;
         loc_ack     <= 1'b0;
         loc_rdata   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  op_loc    <= sel_loc;
                  op_we     <= sel_we;
                  op_offset <= sel_offset;
                  op_be     <= sel_be;
                  op_data   <= sel_wdata;
                  state     <= first_state(sel_we, sel_be);
               end
            end
            RD:   state <= CAP;
            CAP: begin
               op_data <= cap_data;
               state   <= op_we ? WR : DONE;
            end
            WR:   state <= DONE;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase

         bus_done <= fin && !fin_loc;
         loc_ack  <= fin && fin_loc;
         if (fin && !fin_loc) begin
            bus_rdata <= fin_data;
         end
         if (fin && fin_loc) begin
            loc_rdata <= fin_data;
         end

         // A bus strobe the sequencer cannot take now goes to pend unless pend stays occupied.
         if (state == IDLE && pend_v) begin
            pend_v <= 1'b0;
         end
         if (bus_en) begin
            if (pend_v && state != IDLE) begin
               bus_ovf <= 1'b1;
            end else if (pend_v || state != IDLE) begin
               pend_v      <= 1'b1;
               pend_we     <= bus_we;
               pend_offset <= bus_offset;
               pend_be     <= bus_be;
               pend_wdata  <= bus_wdata;
            end
         end
      end
   end

   assign bus_busy = (state != IDLE) || pend_v;
   assign rf_en    = (state == RD) || (state == WR);
   assign rf_we    = (state == WR);
   assign rf_addr  = rf_en ? op_offset : {ADDR_W{1'b0}};
   assign rf_wdata = (state == WR) ? op_data : 32'h0;

endmodule

// File: tb/tb_pci_cfg_arbiter.sv
// Scoreboard bench for pci_cfg_arbiter: a register-file model, directed scenarios
// and a short random phase; expectations come from a bench-side shadow of the file.
module tb_pci_cfg_arbiter;

   logic        clk;
   logic        rst;
   logic        bus_en, bus_we;
   logic [5:0]  bus_offset;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_busy, bus_done, bus_ovf;
   logic [31:0] bus_rdata;
   logic        loc_req, loc_we;
   logic [5:0]  loc_offset;
   logic [3:0]  loc_be;
   logic [31:0] loc_wdata;
   logic        loc_ack;
   logic [31:0] loc_rdata;
   logic        rf_en, rf_we;
   logic [5:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata;

   pci_cfg_arbiter #(.ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .bus_en(bus_en), .bus_we(bus_we), .bus_offset(bus_offset), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_busy(bus_busy), .bus_done(bus_done),
      .bus_rdata(bus_rdata), .bus_ovf(bus_ovf),
      .loc_req(loc_req), .loc_we(loc_we), .loc_offset(loc_offset), .loc_be(loc_be),
      .loc_wdata(loc_wdata), .loc_ack(loc_ack), .loc_rdata(loc_rdata),
      .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .rf_rdata(rf_rdata)
   );

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        bus_q[$];
   exp_t        loc_q[$];
   logic [31:0] mem [64] = '{default: 32'h0};
   logic [31:0] shadow [64];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          drive_cyc;
   int          rf_cnt = 0, wr_cnt = 0;
   int          last_rd_cyc = -1, last_wr_cyc = -1;
   logic [5:0]  last_rd_addr, last_wr_addr;
   logic [31:0] last_wr_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Register file model: read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (rf_en && rf_we) mem[rf_addr] <= rf_wdata;
      if (rf_en && !rf_we) rf_rdata <= mem[rf_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: pops expectations on each completion strobe, logs file traffic.
   always @(negedge clk) begin
      exp_t e;
      if (bus_done === 1'b1) begin
         if (bus_q.size() == 0) check("bus_extra_done", 32'd1, 32'd0);
         else begin
            e = bus_q.pop_front();
            check("bus_rdata", bus_rdata, e.data);
            check("bus_done_cycle", cyc, e.due);
         end
      end
      if (loc_ack === 1'b1) begin
         if (loc_q.size() == 0) check("loc_extra_ack", 32'd1, 32'd0);
         else begin
            e = loc_q.pop_front();
            check("loc_rdata", loc_rdata, e.data);
            check("loc_ack_cycle", cyc, e.due);
         end
      end
      if (rf_en === 1'b1) rf_cnt++;
      if (rf_en === 1'b1 && rf_we === 1'b1) begin
         wr_cnt++;
         last_wr_cyc  = cyc;
         last_wr_addr = rf_addr;
         last_wr_data = rf_wdata;
      end
      if (rf_en === 1'b1 && rf_we === 1'b0) begin
         last_rd_cyc  = cyc;
         last_rd_addr = rf_addr;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic int lat_of(input logic we, input logic [3:0] be);
      if (!we) return 3;
      if (be == 4'hF) return 2;
      if (be == 4'h0) return 1;
      return 4;
   endfunction

   function automatic logic [31:0] exp_of(input logic we, input logic [5:0] off,
                                          input logic [3:0] be, input logic [31:0] wd);
      if (!we) return shadow[off];
      if (be == 4'h0) return wd;
      return byte_merge(shadow[off], wd, be);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // One-cycle bus strobe; extra delays the expected strobe when the access is queued.
   task automatic bus_op(input logic we, input logic [5:0] off, input logic [3:0] be,
                         input logic [31:0] wd, input int extra, input bit push);
      exp_t e;
      e.data = exp_of(we, off, be, wd);
      e.due  = cyc + lat_of(we, be) + extra;
      if (push) begin
         bus_q.push_back(e);
         if (we) shadow[off] = e.data;
      end
      drive_cyc  = cyc;
      bus_en     = 1'b1;
      bus_we     = we;
      bus_offset = off;
      bus_be     = be;
      bus_wdata  = wd;
      step();
      bus_en = 1'b0;
   endtask

   task automatic loc_start(input logic we, input logic [5:0] off, input logic [3:0] be,
                            input logic [31:0] wd, input int extra);
      exp_t e;
      e.data = exp_of(we, off, be, wd);
      e.due  = cyc + lat_of(we, be) + extra;
      loc_q.push_back(e);
      if (we) shadow[off] = e.data;
      loc_req    = 1'b1;
      loc_we     = we;
      loc_offset = off;
      loc_be     = be;
      loc_wdata  = wd;
   endtask

   // Holds loc_req until the acknowledge, then releases it like a registered requester.
   task automatic wait_loc();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (loc_ack === 1'b1) seen = 1'b1;
      end
      check("loc_ack_seen", 32'(seen), 32'd1);
      step();
      loc_req = 1'b0;
   endtask

   task automatic check_reset(input string p);
      check({p, "_busy"},  32'(bus_busy), 32'd0);
      check({p, "_done"},  32'(bus_done), 32'd0);
      check({p, "_ovf"},   32'(bus_ovf),  32'd0);
      check({p, "_ack"},   32'(loc_ack),  32'd0);
      check({p, "_rf_en"}, 32'(rf_en),    32'd0);
      check({p, "_rf_we"}, 32'(rf_we),    32'd0);
      check({p, "_addr"},  32'(rf_addr),  32'd0);
      check({p, "_wdata"}, rf_wdata,      32'd0);
      check({p, "_brd"},   bus_rdata,     32'd0);
      check({p, "_lrd"},   loc_rdata,     32'd0);
   endtask

   initial begin
      int c, rc, wc;
      logic [3:0] be;
      for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
      rst = 1'b0;
      bus_en = 1'b0; bus_we = 1'b0; bus_offset = 6'd0; bus_be = 4'h0; bus_wdata = 32'h0;
      loc_req = 1'b0; loc_we = 1'b0; loc_offset = 6'd0; loc_be = 4'h0; loc_wdata = 32'h0;
      idle(3);
      @(negedge clk);
      check_reset("rst0");
      step();
      rst = 1'b1;
      idle(2);

      // Preload through full writes.
      bus_op(1'b1, 6'h04, 4'hF, 32'h12345678, 0, 1'b1); idle(3);
      bus_op(1'b1, 6'h10, 4'hF, 32'h11223344, 0, 1'b1); idle(3);
      bus_op(1'b1, 6'h08, 4'hF, 32'h55667788, 0, 1'b1); idle(3);
      bus_op(1'b1, 6'h0C, 4'hF, 32'h0A0B0C0D, 0, 1'b1); idle(3);

      // Plain read.
      bus_op(1'b0, 6'h04, 4'h0, 32'h0, 0, 1'b1);
      c = drive_cyc;
      idle(5);
      check("t1_rd_cycle", 32'(last_rd_cyc), 32'(c + 1));
      check("t1_rd_addr", 32'(last_rd_addr), 32'h04);

      // Partial write: read-modify-write.
      bus_op(1'b1, 6'h10, 4'b0101, 32'hAABBCCDD, 0, 1'b1);
      c = drive_cyc;
      idle(6);
      check("t2_rd_cycle", 32'(last_rd_cyc), 32'(c + 1));
      check("t2_wr_cycle", 32'(last_wr_cyc), 32'(c + 3));
      check("t2_wr_addr", 32'(last_wr_addr), 32'h10);
      check("t2_wr_data", last_wr_data, 32'h11BB33DD);

      // Simultaneous local full write and bus read: bus first.
      wc = wr_cnt;
      loc_start(1'b1, 6'h20, 4'hF, 32'hCAFEF00D, 4);
      bus_op(1'b0, 6'h04, 4'h0, 32'h0, 0, 1'b1);
      c = drive_cyc;
      wait_loc();
      idle(3);
      check("t3_wr_count", 32'(wr_cnt - wc), 32'd1);
      check("t3_wr_cycle", 32'(last_wr_cyc), 32'(c + 5));
      bus_op(1'b0, 6'h20, 4'h0, 32'h0, 0, 1'b1);
      idle(5);

      // Local partial write with two bus strobes: one pended, one dropped.
      loc_start(1'b1, 6'h08, 4'b0011, 32'h0000BEEF, 0);
      step();
      bus_op(1'b0, 6'h04, 4'h0, 32'h0, 4, 1'b1);
      bus_op(1'b0, 6'h10, 4'h0, 32'h0, 0, 1'b0);
      check("t4_ovf_set", 32'(bus_ovf), 32'd1);
      wait_loc();
      idle(8);
      check("t4_ovf_sticky", 32'(bus_ovf), 32'd1);

      // Null write: no file access at all.
      rc = rf_cnt;
      bus_op(1'b1, 6'h30, 4'h0, 32'h13579BDF, 0, 1'b1);
      idle(4);
      check("t5_no_rf", 32'(rf_cnt - rc), 32'd0);

      // Reset during CAP of a partial write.
      wc = wr_cnt;
      bus_op(1'b1, 6'h0C, 4'b0001, 32'hFFFFFFAA, 0, 1'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset("t6");
      step();
      rst = 1'b1;
      idle(4);
      check("t6_no_write", 32'(wr_cnt - wc), 32'd0);
      bus_op(1'b0, 6'h0C, 4'h0, 32'h0, 0, 1'b1);
      idle(5);

      // Random sequential bus traffic against the shadow.
      for (int k = 0; k < 12; k++) begin
         case ($urandom_range(0, 2))
            0:       be = 4'h0;
            1:       be = 4'hF;
            default: be = 4'($urandom_range(1, 14));
         endcase
         bus_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), be, $urandom, 0, 1'b1);
         idle(6);
      end

      check("bus_q_drained", 32'(bus_q.size()), 32'd0);
      check("loc_q_drained", 32'(loc_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
